soc1_key_poller: RTL and testbench

Avalon-MM master that periodically reads the 2-bit key PIO slave at word offset 0 and turns raw key levels into debounced state, single-cycle press/release events and a sticky interrupt. It sits between the system interconnect and the Minesweeper game logic, so the game FSM consumes clean per-key events instead of polling the bus itself.

---
 rtl/soc1_key_poller_pkg.sv | 20 ++
 rtl/soc1_key_debounce.sv | 59 +++++
 rtl/soc1_key_poller.sv | 117 +++++++++++
 tb/tb_soc1_key_poller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/soc1_key_poller_pkg.sv
// Shared types and constants for the key poller and its per-key debouncer.
package soc1_key_poller_pkg;

  // Bus-side poll FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LAT  = 2'd2
  } poll_state_e;

  // Logical key levels after polarity correction
  localparam logic KEY_PRESSED  = 1'b1;
  localparam logic KEY_RELEASED = 1'b0;

  // Width of the poll timer that counts 0..div-1
  function automatic int poll_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/soc1_key_debounce.sv
// Per-key debouncer: shifts in one polled sample per strobe and flips the
// stable state only once the whole history agrees on the opposite level.
module soc1_key_debounce
  import soc1_key_poller_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_stb_i,
  input  logic sample_i,
  output logic key_state_o,
  output logic press_o,
  output logic release_o
);

  logic [DEBOUNCE-1:0] hist_q;
  logic [DEBOUNCE-1:0] hist_d;
  logic                state_q;
  logic                press_q;
  logic                release_q;
  logic                all_pressed;
  logic                all_released;

  // History as it will look once the current sample is shifted in
  always_comb begin
    hist_d       = {hist_q[DEBOUNCE-2:0], sample_i};
    all_pressed  = &hist_d;
    all_released = ~|hist_d;
  end

  // History, stable level and one-cycle event pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q    <= {DEBOUNCE{KEY_RELEASED}};
      state_q   <= KEY_RELEASED;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (sample_stb_i) begin
        hist_q <= hist_d;
        if (all_pressed && (state_q == KEY_RELEASED)) begin
          state_q <= KEY_PRESSED;
          press_q <= 1'b1;
        end else if (all_released && (state_q == KEY_PRESSED)) begin
          state_q   <= KEY_RELEASED;
          release_q <= 1'b1;
        end
      end
    end
  end

  assign key_state_o = state_q;
  assign press_o     = press_q;
  assign release_o   = release_q;

endmodule

// File: rtl/soc1_key_poller.sv
// Avalon-MM master that periodically reads the key PIO, debounces each key
// and raises a sticky interrupt on every debounced press.
module soc1_key_poller
  import soc1_key_poller_pkg::*;
#(
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE     = 4,
  parameter int READ_LATENCY = 1,
  parameter int KEY_WIDTH    = 2,
  parameter int ACTIVE_LOW   = 1,
  parameter int ADDR_W       = 3,
  parameter int KEY_BASE     = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [ADDR_W-1:0]    avm_address,
  output logic                 avm_read,
  input  logic [31:0]          avm_readdata,
  input  logic                 avm_waitrequest,
  output logic [KEY_WIDTH-1:0] key_state,
  output logic [KEY_WIDTH-1:0] press_event,
  output logic [KEY_WIDTH-1:0] release_event,
  output logic                 irq,
  input  logic [KEY_WIDTH-1:0] irq_ack
);

  localparam int PCW = poll_cnt_w(POLL_DIV);
  localparam int LCW = $clog2(READ_LATENCY) + 1;

  poll_state_e          state_q;
  logic [PCW-1:0]       timer_q;
  logic [LCW-1:0]       lat_q;
  logic                 read_q;
  logic [KEY_WIDTH-1:0] samp_q;
  logic                 stb_q;
  logic [KEY_WIDTH-1:0] irq_pending_q;
  logic [KEY_WIDTH-1:0] pressed;
  logic                 unused_rdata;

  assign pressed      = (ACTIVE_LOW != 0) ? ~avm_readdata[KEY_WIDTH-1:0]
                                          :  avm_readdata[KEY_WIDTH-1:0];
  assign unused_rdata = ^avm_readdata[31:KEY_WIDTH];

  // Poll sequencer: idle timer, stalled request, fixed-latency wait, capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      lat_q   <= '0;
      read_q  <= 1'b0;
      samp_q  <= '0;
      stb_q   <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (timer_q == PCW'(POLL_DIV - 1)) begin
            timer_q <= '0;
            state_q <= ST_REQ;
            read_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + PCW'(1);
          end
        end
        ST_REQ: begin
          if (!avm_waitrequest) begin
            state_q <= ST_LAT;
            read_q  <= 1'b0;
            lat_q   <= '0;
          end
        end
        ST_LAT: begin
          if (lat_q == LCW'(READ_LATENCY - 1)) begin
            state_q <= ST_IDLE;
            samp_q  <= pressed;
            stb_q   <= 1'b1;
          end else begin
            lat_q <= lat_q + LCW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  assign avm_read    = read_q;
  assign avm_address = ADDR_W'(KEY_BASE);

  for (genvar g = 0; g < KEY_WIDTH; g++) begin : g_key
    soc1_key_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_deb (
      .clk         (clk),
      .reset_n     (reset_n),
      .sample_stb_i(stb_q),
      .sample_i    (samp_q[g]),
      .key_state_o (key_state[g]),
      .press_o     (press_event[g]),
      .release_o   (release_event[g])
    );
  end

  // Sticky press flags; a new press outranks a simultaneous acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pending_q <= '0;
    end else begin
      irq_pending_q <= (irq_pending_q & ~irq_ack) | press_event;
    end
  end

  assign irq = |irq_pending_q;

endmodule

// File: tb/tb_soc1_key_poller.sv
// Directed bench for soc1_key_poller with a 1-cycle registered key PIO model.
module tb_soc1_key_poller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  avm_address;
  logic        avm_read;
  logic [31:0] rdata = 32'hFFFF_FFFF;
  logic        waitrequest;
  logic [1:0]  key_state;
  logic [1:0]  press_event;
  logic [1:0]  release_event;
  logic        irq;
  logic [1:0]  irq_ack;
  logic [1:0]  keys;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int exp_rise;
  int pc[2];
  int rc[2];

  always #5 clk = ~clk;

  soc1_key_poller #(
    .POLL_DIV(8), .DEBOUNCE(3), .READ_LATENCY(1), .KEY_WIDTH(2),
    .ACTIVE_LOW(1), .ADDR_W(3), .KEY_BASE(0)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (rdata),
    .avm_waitrequest(waitrequest),
    .key_state      (key_state),
    .press_event    (press_event),
    .release_event  (release_event),
    .irq            (irq),
    .irq_ack        (irq_ack)
  );

  // Registered slave: data returned one cycle after the accepted read
  always @(posedge clk) begin
    if (avm_read && !waitrequest) rdata <= {30'h0, keys};
  end

  // Edge counter since reset release
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Event pulse counters sampled mid-cycle
  initial begin
    pc[0] = 0; pc[1] = 0; rc[0] = 0; rc[1] = 0;
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (press_event[k])   pc[k] = pc[k] + 1;
      if (release_event[k]) rc[k] = rc[k] + 1;
    end
  end

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL row %0d %s: actual %0h required %0h", row, name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] lvl;
    int         ws;
    logic [1:0] ack;
    logic [1:0] st;
    logic [1:0] pm;
    logic [1:0] rm;
    logic       irq;
    logic       post_ack;
  } vec_t;

  vec_t tbl[17];

  // One full poll: wait for the read, stall, capture, then check outcome
  task automatic do_poll(input int row, input vec_t v);
    int  rise;
    bit  seen;
    bit  stall_ok;
    int  pb[2];
    int  rb[2];
    seen = 1'b0;
    rise = 0;
    keys = v.lvl;
    for (int k = 0; k < 2; k++) begin
      pb[k] = pc[k];
      rb[k] = rc[k];
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (avm_read) begin
        seen = 1'b1;
        rise = cyc;
        break;
      end
    end
    chk("read_seen", row, 32'(seen), 32'd1);
    if (!seen) return;
    chk("rise_cycle", row, rise, exp_rise);
    chk("address", row, 32'(avm_address), 32'd0);
    if (v.ws > 0) begin
      stall_ok = 1'b1;
      waitrequest = 1'b1;
      for (int c = 0; c < v.ws; c++) begin
        @(posedge clk); #1;
        if (!(avm_read && avm_address == 3'd0)) stall_ok = 1'b0;
      end
      waitrequest = 1'b0;
      chk("stall_hold", row, 32'(stall_ok), 32'd1);
    end
    @(posedge clk); #1;
    chk("read_drop", row, 32'(avm_read), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    irq_ack = v.ack;
    @(posedge clk); #1;
    irq_ack = 2'b00;
    chk("key_state", row, 32'(key_state), 32'(v.st));
    for (int k = 0; k < 2; k++) begin
      chk("press_cnt", row, pc[k] - pb[k], 32'(v.pm[k]));
      chk("release_cnt", row, rc[k] - rb[k], 32'(v.rm[k]));
    end
    chk("irq", row, 32'(irq), 32'(v.irq));
    exp_rise = rise + 10 + v.ws;
    if (v.post_ack) begin
      irq_ack = 2'b01;
      @(posedge clk); #1;
      irq_ack = 2'b00;
      chk("irq_after_ack", row, 32'(irq), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    bit   seen;
    vec_t idle_v;
    //            lvl    ws ack    st     pm     rm     irq  post
    tbl[0]  = '{2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[5]  = '{2'b10, 0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[6]  = '{2'b11, 0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{2'b11, 0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0};
    tbl[9]  = '{2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[10] = '{2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[11] = '{2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[12] = '{2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[13] = '{2'b11, 5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[14] = '{2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[15] = '{2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[16] = '{2'b10, 0, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1};
    idle_v  = '{2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};

    reset_n     = 1'b0;
    keys        = 2'b11;
    waitrequest = 1'b0;
    irq_ack     = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read", -1, 32'(avm_read), 32'd0);
    chk("rst_addr", -1, 32'(avm_address), 32'd0);
    chk("rst_state", -1, 32'(key_state), 32'd0);
    chk("rst_events", -1, 32'({press_event, release_event}), 32'd0);
    chk("rst_irq", -1, 32'(irq), 32'd0);
    @(negedge clk);
    reset_n  = 1'b1;
    exp_rise = 8;

    for (int i = 0; i < 17; i++) do_poll(i, tbl[i]);

    // Reset while a read is stalled in the request phase
    seen = 1'b0;
    keys = 2'b10;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (avm_read) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_req_seen", 100, 32'(seen), 32'd1);
    waitrequest = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_pre_state", 100, 32'(key_state), 32'd1);
    chk("rst_req_pre_read", 100, 32'(avm_read), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_req_read", 100, 32'(avm_read), 32'd0);
    chk("rst_req_state", 100, 32'(key_state), 32'd0);
    chk("rst_req_irq", 100, 32'(irq), 32'd0);
    waitrequest = 1'b0;
    keys        = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    exp_rise = 8;
    do_poll(101, idle_v);
    do_poll(102, idle_v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
